// File: rtl/c_jk.sv
`default_nettype none
// ============================================================================
//  Module      : c_jk
//  Description : Bank of WIDTH independent JK flip-flops built as a JK-from-D
//                conversion. Each bit's D input is derived from its own J, K
//                and current state; the D register drives q directly.
//
//  Ports       : clk  - sole clock, all state updates on the rising edge
//                rst  - synchronous, active-high reset (loads RESET_VAL)
//                j    - per-bit J (set) control, WIDTH bits
//                k    - per-bit K (reset) control, WIDTH bits
//                q    - registered flip-flop state, WIDTH bits
//                qn   - complement of q (only when C_JK_QN_EN is defined)
//
//  Parameters  : WIDTH     - number of independent flip-flop bits (>= 1)
//                RESET_VAL - value loaded into q on reset
//
//  Build macro : C_JK_QN_EN - when defined, adds the qn output port.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module c_jk #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q
`ifdef C_JK_QN_EN
   ,
   output logic [WIDTH-1:0] qn
`endif
);

   // Internal D register holding the flip-flop state, one bit per lane.
   logic [WIDTH-1:0] r_q;

   // Next-state for the D register: set when J and currently low, keep when
   // K is low and currently high. This covers hold/set/clear/toggle bitwise,
   // so lanes never interact.
   logic [WIDTH-1:0] w_d;

   assign w_d = (j & ~r_q) | (~k & r_q);

   // Reset wins over every JK action, including toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_d;
      end
   end

   // Output comes straight from the register: no path from j, k or rst.
   assign q = r_q;

`ifdef C_JK_QN_EN
   // Complement is taken from the same register, so it tracks q exactly,
   // including the complement of RESET_VAL during reset.
   assign qn = ~r_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c_jk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c_jk
//  Description : Self-checking bench for c_jk (WIDTH=4). Directed sequences
//                for reset, set/clear, hold, toggle and mid-operation reset,
//                followed by randomized traffic, all scored against a
//                truth-table reference model. Inputs are disturbed between
//                clock edges to confirm q only moves on rising edges.
//
//  Build macro : C_JK_QN_EN - also exercises qn and RESET_VAL = 4'b1010.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c_jk;

   localparam int W = 4;
`ifdef C_JK_QN_EN
   localparam logic [W-1:0] RV = 4'b1010;
`else
   localparam logic [W-1:0] RV = 4'b0000;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic [W-1:0] q;
`ifdef C_JK_QN_EN
   logic [W-1:0] qn;
`endif

   int n_checks   = 0;
   int n_failures = 0;

   logic [W-1:0] m_q;        // reference model state
   bit           m_valid = 0; // model known only after the first reset edge

   always #5 clk = ~clk;

   c_jk #(
      .WIDTH     (W),
      .RESET_VAL (RV)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .j   (j),
      .k   (k),
      .q   (q)
`ifdef C_JK_QN_EN
      ,
      .qn  (qn)
`endif
   );

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: JK truth table applied per bit.
   function automatic logic [W-1:0] jk_model(input logic [W-1:0] cur,
                                             input logic [W-1:0] jv,
                                             input logic [W-1:0] kv,
                                             input logic rv);
      logic [W-1:0] nxt;
      if (rv) return RV;
      for (int b = 0; b < W; b++) begin
         case ({jv[b], kv[b]})
            2'b00:   nxt[b] = cur[b];
            2'b01:   nxt[b] = 1'b0;
            2'b10:   nxt[b] = 1'b1;
            default: nxt[b] = ~cur[b];
         endcase
      end
      return nxt;
   endfunction

   // One clock: confirm q held steady across the previous mid-cycle
   // disturbance, drive real inputs, check after the edge, then disturb.
   task automatic step(input string tag, input logic [W-1:0] jv,
                       input logic [W-1:0] kv, input logic rv);
      @(negedge clk);
      if (m_valid) check({tag, "_stable"}, q, m_q);
      j   = jv;
      k   = kv;
      rst = rv;
      @(posedge clk);
      m_q     = jk_model(m_q, jv, kv, rv);
      m_valid = m_valid | rv;
      #1;
      if (m_valid) begin
         check(tag, q, m_q);
`ifdef C_JK_QN_EN
         check({tag, "_qn"}, qn, ~m_q);
`endif
      end
      #1;
      j   = W'($urandom);
      k   = W'($urandom);
      rst = 1'($urandom);
   endtask

   initial begin
      rst = 1'b1;
      j   = '1;
      k   = '1;
      m_q = '0;

      // Reset with J=K=1: must load RESET_VAL, no toggle.
      step("reset_jk11", '1, '1, 1'b1);
      check("reset_val", q, RV);

`ifdef C_JK_QN_EN
      step("qn_apply", 4'b0011, 4'b0110, 1'b0);
      check("qn_q1001", q, 4'b1001);
      step("qn_rereset", '0, '0, 1'b1);
      check("qn_rst_q", q, 4'b1010);
      check("qn_rst_qn", qn, 4'b0101);
      step("qn_clr", '0, '1, 1'b0);
`endif

      // Set then clear.
      step("set", '1, '0, 1'b0);
      check("set_one", q, '1);
      step("clear", '0, '1, 1'b0);
      check("clear_zero", q, '0);

      // Hold high for 3 edges, then hold low for 3 edges.
      step("set_h", '1, '0, 1'b0);
      for (int i = 0; i < 3; i++) step("hold1", '0, '0, 1'b0);
      check("hold_one", q, '1);
      step("clr_h", '0, '1, 1'b0);
      for (int i = 0; i < 3; i++) step("hold0", '0, '0, 1'b0);
      check("hold_zero", q, '0);

      // Sustained toggle from 0 for 10 edges ends at 0.
      for (int i = 0; i < 10; i++) step("toggle", '1, '1, 1'b0);
      check("toggle_end", q, '0);

      // Reset in the middle of toggling, then resume.
      for (int i = 0; i < 3; i++) step("tog_pre", '1, '1, 1'b0);
      step("tog_rst", '1, '1, 1'b1);
      check("tog_rst_val", q, RV);
      step("tog_resume", '1, '1, 1'b0);
      check("tog_resume_val", q, ~RV);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++)
         step("rand", W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0));

      @(negedge clk);
      check("final_stable", q, m_q);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/c_jk.md
C_JK -- requirements
Module: c_jk

Interface
REQ-001 Parameter WIDTH, default 1: number of independent JK flip-flop bits.
REQ-002 Parameter RESET_VAL, default {WIDTH{1'b0}}: value loaded into q on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 j  input  WIDTH  per-bit J (set) control.
REQ-006 k  input  WIDTH  per-bit K (reset) control.
REQ-007 q  output  WIDTH  registered flip-flop state.
REQ-008 qn  output  WIDTH  complement of q; present only when C_JK_QN_EN is defined (see Configuration).

Function
REQ-009 The block SHALL be built as a JK-from-D conversion: an internal D register per bit, with next-state logic d = (j & ~q) | (~k & q), bitwise.
REQ-010 On each rising clk edge with rst=0, each bit SHALL update per the JK truth table: j=0,k=0 hold; j=0,k=1 clear to 0; j=1,k=0 set to 1; j=1,k=1 toggle.
REQ-011 Latency SHALL be one clock: q reflects the j/k values sampled at the rising edge, stable until the next rising edge.
REQ-012 Bits SHALL be fully independent; no cross-bit interaction for any WIDTH >= 1.
REQ-013 q SHALL be driven directly from the register, with no combinational path from j, k or rst to q.
REQ-014 Changes on j/k between rising edges SHALL have no effect on q.
REQ-015 Sustained j=1,k=1 SHALL toggle q every rising edge, giving a clk/2 square wave per bit.

Reset
REQ-016 When rst=1 at a rising clk edge, q SHALL load RESET_VAL regardless of j and k.
REQ-017 Reset SHALL take priority over all JK operations, including toggle.
REQ-018 Asserting or deasserting rst between clock edges SHALL have no effect until the next rising edge.
REQ-019 After rst deasserts, the first rising edge with rst=0 SHALL apply normal JK behaviour starting from RESET_VAL.
REQ-020 Before the first reset edge, q is unspecified; benches SHALL NOT check q before then.

Configuration
REQ-021 Macro C_JK_QN_EN: when defined, port qn SHALL exist and equal ~q at all times, including RESET_VAL complement during reset.
REQ-022 When C_JK_QN_EN is not defined, qn SHALL be absent from the port list, and the remaining behaviour SHALL be identical.

Verification
REQ-023 Reset: rst=1, j=1, k=1 at a rising edge -> q=0 (RESET_VAL default), with no toggle.
REQ-024 Set/clear: rst=0; j=1,k=0 at edge -> q=1; then j=0,k=1 at next edge -> q=0.
REQ-025 Hold: q=1, j=0,k=0 for 3 edges -> q stays 1; repeat from q=0 -> stays 0.
REQ-026 Toggle: rst=0 from q=0, j=1,k=1 held for 10 clk periods (period 10 time units) -> q alternates 1,0,1,... each edge, ending at q=0 after 10 edges.
REQ-027 Mid-operation reset: during toggling, rst=1 for one edge -> q=0 at that edge; rst=0 -> toggling resumes with q=1 on the next edge.
REQ-028 With C_JK_QN_EN and WIDTH=4, RESET_VAL=4'b1010: reset -> q=1010, qn=0101; j=4'b0011,k=4'b0110 -> q=1001.
